// File: rtl/safety_sensor_window_monitor.sv
// safety_sensor_window_monitor
// Round-robin poller for a list of sensor channels. Each signed reading is checked
// against a min/max window. Violations are debounced per slot, and over, under and
// timeout faults are latched as sticky bits for the safety controller.

module safety_sensor_window_monitor #(
    parameter int P_NO_CHANNELS      = 9,
    parameter int P_NO_TEMP_CHANNELS = 5,
    parameter int P_CH_W             = 4,
    parameter int P_DATA_W           = 32,
    parameter logic [P_NO_TEMP_CHANNELS*P_CH_W-1:0] P_CH_MAP = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0},
    parameter int P_MAX_TEMP         = 60,
    parameter int P_MIN_TEMP         = 0,
    parameter int P_DEBOUNCE         = 3,
    parameter int P_TIMEOUT          = 1024,
    localparam int SLOT_W = (P_NO_TEMP_CHANNELS > 1) ? $clog2(P_NO_TEMP_CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_enable,
    output logic                          o_req_valid,
    input  logic                          i_req_ready,
    output logic [P_CH_W-1:0]             o_req_channel,
    input  logic                          i_rsp_valid,
    input  logic [P_CH_W-1:0]             i_rsp_channel,
    input  logic [P_DATA_W-1:0]           i_rsp_data,
    input  logic [P_NO_TEMP_CHANNELS-1:0] i_fault_clear,
    output logic [P_NO_TEMP_CHANNELS-1:0] o_over_fault,
    output logic [P_NO_TEMP_CHANNELS-1:0] o_under_fault,
    output logic [P_NO_TEMP_CHANNELS-1:0] o_timeout_fault,
    output logic                          o_any_fault,
    output logic                          o_sample_valid,
    output logic [SLOT_W-1:0]             o_sample_slot,
    output logic [P_DATA_W-1:0]           o_sample_data
);

    localparam int N     = P_NO_TEMP_CHANNELS;
    localparam int TMR_W = $clog2(P_TIMEOUT);
    localparam int CNT_W = $clog2(P_DEBOUNCE + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_EVAL = 2'd3;

    localparam logic signed [P_DATA_W-1:0] MAX_W     = P_DATA_W'(P_MAX_TEMP);
    localparam logic signed [P_DATA_W-1:0] MIN_W     = P_DATA_W'(P_MIN_TEMP);
    localparam logic        [TMR_W-1:0]    TMO_LAST  = TMR_W'(P_TIMEOUT - 1);
    localparam logic        [CNT_W-1:0]    CNT_MAX   = CNT_W'(P_DEBOUNCE);
    localparam logic        [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(N - 1);

    logic [1:0]                  state;
    logic [SLOT_W-1:0]           slot;
    logic [SLOT_W-1:0]           slot_next;
    logic [TMR_W-1:0]            timer;
    logic signed [P_DATA_W-1:0]  cap_data;
    logic [CNT_W-1:0]            deb_cnt  [N];
    logic                        deb_over [N];
    logic [P_CH_W-1:0]           ch_map   [N];
    logic [P_CH_W-1:0]           cur_ch;
    logic                        rsp_match;
    logic                        is_over;
    logic                        is_under;
    logic                        violation;
    logic [CNT_W-1:0]            cnt_eval;
    logic                        fault_hit;

    // Unpack the channel map once so the slot lookup is a plain array index
    for (genvar k = 0; k < N; k++) begin : g_map
        assign ch_map[k] = P_CH_MAP[k*P_CH_W +: P_CH_W];
    end

    assign cur_ch        = ch_map[slot];
    assign o_req_valid   = (state == S_REQ);
    assign o_req_channel = o_req_valid ? cur_ch : '0;
    assign slot_next     = (slot == LAST_SLOT) ? '0 : slot + 1'b1;

    // Only a response from a channel that exists on the bus and matches the polled one counts
    assign rsp_match = i_rsp_valid
                       && (32'(i_rsp_channel) < P_NO_CHANNELS)
                       && (i_rsp_channel == cur_ch);

    assign is_over   = (cap_data > MAX_W);
    assign is_under  = (cap_data < MIN_W);
    assign violation = is_over | is_under;

    // Next debounce count for the slot being evaluated; a direction flip restarts at one
    always_comb begin
        cnt_eval = deb_cnt[slot];
        if (!violation) begin
            cnt_eval = '0;
        end else if ((deb_cnt[slot] != '0) && (deb_over[slot] != is_over)) begin
            cnt_eval = CNT_W'(1);
        end else if (deb_cnt[slot] != CNT_MAX) begin
            cnt_eval = deb_cnt[slot] + 1'b1;
        end
    end

    assign fault_hit = violation && (cnt_eval == CNT_MAX);

    // Scan FSM, debounce bookkeeping and sticky fault flags; later set assignments override clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            slot            <= '0;
            timer           <= '0;
            cap_data        <= '0;
            o_over_fault    <= '0;
            o_under_fault   <= '0;
            o_timeout_fault <= '0;
            o_any_fault     <= 1'b0;
            o_sample_valid  <= 1'b0;
            o_sample_slot   <= '0;
            o_sample_data   <= '0;
            for (int k = 0; k < N; k++) begin
                deb_cnt[k]  <= '0;
                deb_over[k] <= 1'b0;
            end
        end else begin
            o_sample_valid  <= 1'b0;
            o_any_fault     <= (|o_over_fault) | (|o_under_fault) | (|o_timeout_fault);
            o_over_fault    <= o_over_fault    & ~i_fault_clear;
            o_under_fault   <= o_under_fault   & ~i_fault_clear;
            o_timeout_fault <= o_timeout_fault & ~i_fault_clear;
            for (int k = 0; k < N; k++) begin
                if (i_fault_clear[k]) begin
                    deb_cnt[k] <= '0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_req_ready) begin
                        state <= S_WAIT;
                        timer <= '0;
                    end
                end
                S_WAIT: begin
                    if (rsp_match) begin
                        cap_data <= i_rsp_data;
                        state    <= S_EVAL;
                    end else if (timer == TMO_LAST) begin
                        o_timeout_fault[slot] <= 1'b1;
                        slot                  <= slot_next;
                        state                 <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_EVAL: begin
                    deb_cnt[slot] <= cnt_eval;
                    if (violation) begin
                        deb_over[slot] <= is_over;
                    end
                    if (fault_hit) begin
                        if (is_over) begin
                            o_over_fault[slot] <= 1'b1;
                        end else begin
                            o_under_fault[slot] <= 1'b1;
                        end
                    end
                    o_sample_valid <= 1'b1;
                    o_sample_slot  <= slot;
                    o_sample_data  <= cap_data;
                    slot           <= slot_next;
                    state          <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safety_sensor_window_monitor.sv
// tb_safety_sensor_window_monitor
// Directed bench: scans with in-range data, over/under debounce, timeout with a
// stray response, clear versus set race, and an asynchronous reset in WAIT.

module tb_safety_sensor_window_monitor;

    localparam int TB_TIMEOUT = 32;

    logic        clk;
    logic        rst;
    logic        i_enable;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [3:0]  o_req_channel;
    logic        i_rsp_valid;
    logic [3:0]  i_rsp_channel;
    logic [31:0] i_rsp_data;
    logic [4:0]  i_fault_clear;
    logic [4:0]  o_over_fault;
    logic [4:0]  o_under_fault;
    logic [4:0]  o_timeout_fault;
    logic        o_any_fault;
    logic        o_sample_valid;
    logic [2:0]  o_sample_slot;
    logic [31:0] o_sample_data;

    int checks     = 0;
    int failures   = 0;
    int pulseCount = 0;

    safety_sensor_window_monitor #(
        .P_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (i_enable),
        .o_req_valid     (o_req_valid),
        .i_req_ready     (i_req_ready),
        .o_req_channel   (o_req_channel),
        .i_rsp_valid     (i_rsp_valid),
        .i_rsp_channel   (i_rsp_channel),
        .i_rsp_data      (i_rsp_data),
        .i_fault_clear   (i_fault_clear),
        .o_over_fault    (o_over_fault),
        .o_under_fault   (o_under_fault),
        .o_timeout_fault (o_timeout_fault),
        .o_any_fault     (o_any_fault),
        .o_sample_valid  (o_sample_valid),
        .o_sample_slot   (o_sample_slot),
        .o_sample_data   (o_sample_data)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count sample pulses independently of the per-scan checks
    always @(posedge clk) begin
        if (o_sample_valid) pulseCount++;
    end

    // Hard stop if the run ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitForReq();
        int waitCycles = 0;
        while (!o_req_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
    endtask

    // One full poll: request seen, response one cycle after the handshake, sample checked
    task automatic applyStimulus(input logic [3:0] expCh, input logic [31:0] data,
                                 input logic [2:0] expSlot, input logic [4:0] clr);
        waitForReq();
        checkOutput("reqValid", 32'(o_req_valid), 1);
        checkOutput("reqChannel", 32'(o_req_channel), 32'(expCh));
        @(negedge clk);
        i_rsp_valid   = 1'b1;
        i_rsp_channel = expCh;
        i_rsp_data    = data;
        @(negedge clk);
        i_rsp_valid   = 1'b0;
        i_fault_clear = clr;
        @(negedge clk);
        i_fault_clear = '0;
        checkOutput("sampleValid", 32'(o_sample_valid), 1);
        checkOutput("sampleSlot", 32'(o_sample_slot), 32'(expSlot));
        checkOutput("sampleData", o_sample_data, data);
    endtask

    logic [31:0] slot0Seq [6];
    logic [31:0] data;
    logic [31:0] expOver;
    logic [31:0] expUnder;

    initial begin
        slot0Seq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        rst           = 1'b1;
        i_enable      = 1'b0;
        i_req_ready   = 1'b1;
        i_rsp_valid   = 1'b0;
        i_rsp_channel = '0;
        i_rsp_data    = '0;
        i_fault_clear = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstReqValid", 32'(o_req_valid), 0);
        checkOutput("rstReqChannel", 32'(o_req_channel), 0);
        checkOutput("rstOver", 32'(o_over_fault), 0);
        checkOutput("rstUnder", 32'(o_under_fault), 0);
        checkOutput("rstTimeout", 32'(o_timeout_fault), 0);
        checkOutput("rstAny", 32'(o_any_fault), 0);
        checkOutput("rstSampleValid", 32'(o_sample_valid), 0);
        checkOutput("rstSampleData", o_sample_data, 0);
        rst      = 1'b0;
        i_enable = 1'b1;

        // T1: one clean round, then the sixth request wraps to channel 0
        for (int s = 0; s < 5; s++) applyStimulus(4'(s), 32'd25, 3'(s), 5'd0);
        @(negedge clk);
        checkOutput("t1Pulses", 32'(pulseCount), 5);
        checkOutput("t1Over", 32'(o_over_fault), 0);
        checkOutput("t1Under", 32'(o_under_fault), 0);
        checkOutput("t1Timeout", 32'(o_timeout_fault), 0);
        checkOutput("t1Any", 32'(o_any_fault), 0);

        // T2/T3: slot 2 over for three rounds, slot 0 under sequence, slot 4 sits on the max
        for (int r = 1; r <= 6; r++) begin
            for (int s = 0; s < 5; s++) begin
                if (s == 0)      data = slot0Seq[r-1];
                else if (s == 2) data = (r <= 3) ? 32'd61 : 32'd25;
                else if (s == 4) data = 32'd60;
                else             data = 32'd25;
                applyStimulus(4'(s), data, 3'(s), 5'd0);
                expOver  = ((r > 3) || (r == 3 && s >= 2)) ? 32'b00100 : 32'b0;
                expUnder = (r == 6) ? 32'b00001 : 32'b0;
                checkOutput("debOver", 32'(o_over_fault), expOver);
                checkOutput("debUnder", 32'(o_under_fault), expUnder);
            end
        end

        // T5a: clear alone with the scanner parked in IDLE
        i_enable = 1'b0;
        @(negedge clk);
        i_fault_clear = 5'b00101;
        @(negedge clk);
        i_fault_clear = '0;
        checkOutput("clrOver", 32'(o_over_fault), 0);
        checkOutput("clrUnder", 32'(o_under_fault), 0);
        checkOutput("clrAnyLag", 32'(o_any_fault), 1);
        @(negedge clk);
        checkOutput("clrAny", 32'(o_any_fault), 0);

        // T5b: re-debounce slot 2 and clear it on the very edge the fault sets
        i_enable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 5; s++) applyStimulus(4'(s), (s == 2) ? 32'd61 : 32'd25, 3'(s), 5'd0);
        end
        checkOutput("raceBefore", 32'(o_over_fault), 0);
        applyStimulus(4'd0, 32'd25, 3'd0, 5'd0);
        applyStimulus(4'd1, 32'd25, 3'd1, 5'd0);
        applyStimulus(4'd2, 32'd61, 3'd2, 5'b00100);
        checkOutput("raceOver", 32'(o_over_fault), 32'b00100);

        // T4: slot 3 never answers, a stray channel 7 response is ignored
        waitForReq();
        checkOutput("tmoReqChannel", 32'(o_req_channel), 3);
        @(negedge clk);
        for (int k = 1; k < TB_TIMEOUT; k++) begin
            if (k == 3) begin
                i_rsp_valid   = 1'b1;
                i_rsp_channel = 4'd7;
                i_rsp_data    = 32'd100;
            end else begin
                i_rsp_valid   = 1'b0;
            end
            @(negedge clk);
        end
        i_rsp_valid = 1'b0;
        checkOutput("tmoEarly", 32'(o_timeout_fault), 0);
        @(negedge clk);
        checkOutput("tmoSet", 32'(o_timeout_fault), 32'b01000);
        checkOutput("tmoNoSample", 32'(o_sample_valid), 0);
        applyStimulus(4'd4, 32'd25, 3'd4, 5'd0);
        checkOutput("tmoAny", 32'(o_any_fault), 1);

        // T6: reset while waiting, with a response on the bus
        waitForReq();
        checkOutput("t6ReqChannel", 32'(o_req_channel), 0);
        @(negedge clk);
        i_rsp_valid   = 1'b1;
        i_rsp_channel = 4'd0;
        i_rsp_data    = 32'hFFFF_FFFB;
        #2 rst = 1'b1;
        #1;
        checkOutput("t6Over", 32'(o_over_fault), 0);
        checkOutput("t6Timeout", 32'(o_timeout_fault), 0);
        checkOutput("t6Any", 32'(o_any_fault), 0);
        checkOutput("t6ReqValid", 32'(o_req_valid), 0);
        checkOutput("t6SampleData", o_sample_data, 0);
        @(negedge clk);
        i_rsp_valid = 1'b0;
        rst         = 1'b0;
        applyStimulus(4'd0, 32'd25, 3'd0, 5'd0);
        checkOutput("t6Under", 32'(o_under_fault), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
